// File: rtl/gray_img_server.sv
// gray_img_server: frame buffer on the far end of the gray_* read interface.
// It loads one grayscale frame over a valid/ready pixel stream (raster order),
// then serves zero-latency reads to the LBP engine until the engine pulses
// finish, and then goes back to loading the next frame.
// Optional macro GRAY_RD_CNT_EN adds a saturating read-request counter on
// rd_cnt; without it rd_cnt is tied to zero.
//
// Handshake: a pixel beat transfers on a rising edge where in_valid and
// in_ready are both high. in_valid may rise regardless of in_ready, and
// in_ready stays high for the whole LOAD phase and low for the whole SERVE phase.
module gray_img_server #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] gray_addr,
    input  logic              gray_req,
    output logic              gray_ready,
    output logic [7:0]        gray_data,
    input  logic              finish,
    output logic              frame_done,
    output logic [23:0]       rd_cnt
);

    localparam int                DEPTH     = IMG_W * IMG_H;
    localparam int                MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic              frame_done_q, frame_done_d;
    logic              beat_accept;
    logic [7:0]        mem [DEPTH];

    // Both status outputs come straight from the registered state, so they
    // change together in the cycle after the last beat or after finish.
    assign in_ready    = (state_q == LOAD);
    assign gray_ready  = (state_q == SERVE);
    assign frame_done  = frame_done_q;
    // Reset takes priority, so a beat presented during reset is dropped.
    assign beat_accept = in_valid && in_ready && !reset;

    // Next-state logic: advance the write pointer on beats, flip to SERVE on the last one.
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        frame_done_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    if (wp_q == LAST_ADDR) begin
                        wp_d    = '0;
                        state_d = SERVE;
                    end else begin
                        wp_d = wp_q + ADDR_W'(1);
                    end
                end
            end
            SERVE: begin
                if (finish) begin
                    state_d      = LOAD;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            wp_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame storage write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (beat_accept) begin
            mem[wp_q[MEM_AW-1:0]] <= in_data;
        end
    end

    // Asynchronous read port: the engine samples data on the edge it presents the address.
    always_comb begin
        gray_data = 8'h00;
        if (gray_req && ({1'b0, gray_addr} < DEPTH_EXT)) begin
            gray_data = mem[gray_addr[MEM_AW-1:0]];
        end
    end

`ifdef GRAY_RD_CNT_EN
    logic [23:0] rd_cnt_q, rd_cnt_d;

    // Count read requests in SERVE (saturating); clear on the first beat of a new frame.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if ((state_q == SERVE) && gray_req && (rd_cnt_q != 24'hFFFFFF)) begin
            rd_cnt_d = rd_cnt_q + 24'd1;
        end else if ((state_q == LOAD) && in_valid && (wp_q == '0)) begin
            rd_cnt_d = '0;
        end
    end

    // Read counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
`else
    assign rd_cnt = 24'h000000;
`endif

endmodule

// File: tb/tb_gray_img_server.sv
// Bench for gray_img_server with a 4x4 frame and a 5-bit address, so that
// addresses 16..31 exercise the out-of-range read path.
module tb_gray_img_server;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int AW    = 5;
  localparam int DEPTH = W * H;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic          gray_ready;
  logic [7:0]    gray_data;
  logic          finish;
  logic          frame_done;
  logic [23:0]   rd_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gray_img_server #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .finish     (finish),
    .frame_done (frame_done),
    .rd_cnt     (rd_cnt)
  );

  // ---------------- reference model ----------------
  // The frame buffer seen as an array plus a "frame loaded" flag.
  logic [7:0] ref_mem [DEPTH];
  bit         ref_known [DEPTH];
  int         ref_wp;
  bit         ref_serving;
  bit         ref_fd;
  int         ref_cnt;

  // ---------------- scoreboard ----------------
  int         n_checks;
  int         n_pass;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input bit rs, input bit v, input logic [7:0] d,
                            input int a, input bit r, input bit f);
    if (rs) begin
      ref_serving = 0;
      ref_wp      = 0;
      ref_fd      = 0;
      ref_cnt     = 0;
    end else begin
      ref_fd = 0;
      if (!ref_serving) begin
        if (v) begin
          ref_mem[ref_wp]   = d;
          ref_known[ref_wp] = 1;
          if (ref_wp == 0) ref_cnt = 0;
          ref_wp++;
          if (ref_wp == DEPTH) begin
            ref_wp      = 0;
            ref_serving = 1;
          end
        end
      end else begin
        if (r && ref_cnt < 24'hFFFFFF) ref_cnt++;
        if (f) begin
          ref_serving = 0;
          ref_fd      = 1;
        end
      end
    end
    if (a < 0) ref_fd = ref_fd; // address unused by the state update
  endtask

  task automatic check_regs();
    int exp_cnt;
`ifdef GRAY_RD_CNT_EN
    exp_cnt = ref_cnt;
`else
    exp_cnt = 0;
`endif
    chk("in_ready",   32'(in_ready),   32'(!ref_serving));
    chk("gray_ready", 32'(gray_ready), 32'(ref_serving));
    chk("frame_done", 32'(frame_done), 32'(ref_fd));
    chk("rd_cnt",     32'(rd_cnt),     32'(exp_cnt));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check the combinational read, clock,
  // update the model, check registered outputs.
  task automatic cycle(input bit v, input logic [7:0] d, input int a, input bit r,
                       input bit f, input bit rs, output logic [7:0] rd);
    reset     = rs;
    in_valid  = v;
    in_data   = d;
    gray_addr = AW'(a);
    gray_req  = r;
    finish    = f;
    #2;
    rd = gray_data;
    if (!r || a >= DEPTH) exp_q.push_back(8'h00);
    else if (ref_known[a]) exp_q.push_back(ref_mem[a]);
    if (!r || a >= DEPTH || ref_known[a]) chk("gray_data", 32'(rd), 32'(exp_q.pop_front()));
    @(posedge clk);
    model_edge(rs, v, d, a, r, f);
    #1;
    check_regs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic [AW-1:0] a;
    logic          r;
    logic          f;
    logic [7:0]    exp_data;
    logic          exp_in_ready;
    logic          exp_gray_ready;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0] rd;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 0;
    ref_wp = 0; ref_serving = 0; ref_fd = 0; ref_cnt = 0;

    // SERVE-phase vectors for a frame holding 0x10+i; in_valid/0xAA rows must not write.
    tbl[0]  = '{1'b0, 8'h00, 5'd5,  1'b1, 1'b0, 8'h15, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 5'd0,  1'b1, 1'b0, 8'h10, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 5'd15, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 5'd31, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 5'd5,  1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'hAA, 5'd3,  1'b1, 1'b0, 8'h13, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 8'hAA, 5'd7,  1'b1, 1'b0, 8'h17, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'hAA, 5'd9,  1'b1, 1'b0, 8'h19, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'hAA, 5'd12, 1'b1, 1'b0, 8'h1C, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'hAA, 5'd0,  1'b1, 1'b0, 8'h10, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 5'd0,  1'b1, 1'b0, 8'h10, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 5'd10, 1'b1, 1'b0, 8'h1A, 1'b0, 1'b1};

    // Reset state.
    cycle(0, 8'h00, 0, 0, 0, 1, rd);
    cycle(0, 8'h00, 0, 0, 0, 1, rd);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_gray_ready", 32'(gray_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rd_cnt",     32'(rd_cnt),     32'd0);

    // Load 0x10..0x1F with in_valid toggling; idle cycles carry junk data.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'hEE, 0, 0, 0, 0, rd);
      chk("load_gray_ready_low", 32'(gray_ready), 32'd0);
      cycle(1, 8'(8'h10 + i), 0, 0, 0, 0, rd);
    end
    chk("last_beat_in_ready",   32'(in_ready),   32'd0);
    chk("last_beat_gray_ready", 32'(gray_ready), 32'd1);

    // Table-driven SERVE reads and ignored writes.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].d, int'(tbl[i].a), tbl[i].r, tbl[i].f, 0, rd);
      chk($sformatf("tbl%0d_data", i), 32'(rd), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_in_ready));
      chk($sformatf("tbl%0d_gray_ready", i), 32'(gray_ready), 32'(tbl[i].exp_gray_ready));
    end
`ifdef GRAY_RD_CNT_EN
    chk("rd_cnt_after_tbl", 32'(rd_cnt), 32'd12);
`endif

    // Whole frame readback: mem[i] = 0x10+i.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, i, 1, 0, 0, rd);
      chk("readback", 32'(rd), 32'(8'h10 + i));
    end

    // finish in SERVE, then finish in LOAD.
    cycle(0, 8'h00, 0, 0, 1, 0, rd);
    chk("fin_frame_done", 32'(frame_done), 32'd1);
    chk("fin_gray_ready", 32'(gray_ready), 32'd0);
    chk("fin_in_ready",   32'(in_ready),   32'd1);
    cycle(0, 8'h00, 0, 0, 0, 0, rd);
    chk("fin_pulse_one_cycle", 32'(frame_done), 32'd0);
    cycle(0, 8'h00, 0, 0, 1, 0, rd);
    chk("fin_in_load_ignored", 32'(frame_done), 32'd0);
    cycle(0, 8'h00, 0, 0, 0, 0, rd);
    chk("fin_in_load_ignored2", 32'(frame_done), 32'd0);
`ifdef GRAY_RD_CNT_EN
    chk("rd_cnt_hold_in_load", 32'(rd_cnt), 32'd28);
`endif

    // Seven beats, reset, then a full frame of 0x80+i.
    for (int i = 0; i < 7; i++) cycle(1, 8'(8'h40 + i), 0, 0, 0, 0, rd);
`ifdef GRAY_RD_CNT_EN
    chk("rd_cnt_clear_first_beat", 32'(rd_cnt), 32'd0);
`endif
    cycle(0, 8'h00, 0, 0, 0, 1, rd);
    for (int i = 0; i < DEPTH; i++) begin
      chk("reload_gray_ready_low", 32'(gray_ready), 32'd0);
      cycle(1, 8'(8'h80 + i), 0, 0, 0, 0, rd);
    end
    chk("reload_gray_ready", 32'(gray_ready), 32'd1);
    cycle(0, 8'h00, 0, 1, 0, 0, rd);
    chk("reload_mem0", 32'(rd), 32'h80);
    cycle(0, 8'h00, 15, 1, 0, 0, rd);
    chk("reload_mem15", 32'(rd), 32'h8F);
    cycle(0, 8'h00, 7, 1, 0, 0, rd);
    chk("reload_mem7", 32'(rd), 32'h87);

    // Randomized traffic against the model, with occasional reset.
    for (int n = 0; n < 1500; n++) begin
      bit v, r, f, rs;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 1) == 1);
      f  = ref_serving ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cycle(v, 8'($urandom_range(0, 255)), int'($urandom_range(0, 31)), r, f, rs, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
